ram_arbiter: RTL
================

// Module: ram_arbiter
// PURPOSE
//  Shares the single-port RAM between the instruction-fetch path (iREN) and the data path
//  (dREN/dWEN) driven by the control unit. A registered FSM grants one requester at a time,
//  holds the grant until the RAM reports ACCESS, and stalls the other side via its wait line.
//  Data has priority; a starvation counter forces an instruction grant after repeated data wins.
//  A timeout counter traps a hung RAM into a sticky error state.
// PARAMETERS
//  STARVE_LIMIT  4   consecutive data completions (iREN pending) before a forced instruction grant
//  TIMEOUT       16  cycles a grant may wait for ACCESS before entering ERR
// PORTS
//  CLK       in   1   system clock, rising edge
//  nRST      in   1   asynchronous reset, active low
//  iREN      in   1   instruction read request
//  iaddr     in   32  instruction address (word_t)
//  iwait     out  1   instruction stall; 0 = iload valid this cycle
//  iload     out  32  instruction read data
//  dREN      in   1   data read request
//  dWEN      in   1   data write request
//  daddr     in   32  data address
//  dstore    in   32  data write value
//  dwait     out  1   data stall; 0 = access completes this cycle
//  dload     out  32  data read data
//  ramREN    out  1   RAM read strobe
//  ramWEN    out  1   RAM write strobe
//  ramaddr   out  32  RAM address
//  ramstore  out  32  RAM write data
//  ramload   in   32  RAM read data
//  ramstate  in   2   ramstate_t: FREE, BUSY, ACCESS, ERROR
//  arb_err   out  1   sticky error flag
// BEHAVIOUR
//  - States: IDLE, IGRANT, DGRANT, ERR. Reset: IDLE, starve_cnt=0, tmo_cnt=0, arb_err=0,
//    ramREN=ramWEN=0, ramaddr=ramstore=0. During reset iwait=iREN, dwait=dREN|dWEN.
//  - IDLE: no RAM strobes. Next state: DGRANT if (dREN|dWEN) and not (iREN and
//    starve_cnt==STARVE_LIMIT); else IGRANT if iREN; else IDLE.
//  - IGRANT: ramREN=1, ramaddr=iaddr. DGRANT: ramaddr=daddr, ramstore=dstore; ramWEN=dWEN,
//    ramREN=dREN&~dWEN (dREN and dWEN together is a write).
//  - Completion: in a grant state with ramstate==ACCESS, drop that side's wait for exactly that
//    cycle, pass ramload to iload/dload, go to IDLE. Minimum latency from request to wait=0 is
//    2 cycles (IDLE cycle + one ACCESS cycle).
//  - iwait=iREN & ~icomplete; dwait=(dREN|dWEN) & ~dcomplete, combinational, in every state.
//  - iload/dload = ramload continuously; valid only when matching wait=0.
//  - Withdrawal: grantee drops its request mid-grant (flush) -> IDLE next cycle, no completion,
//    no counter update.
//  - starve_cnt: +1 on a data completion while iREN=1, saturating at STARVE_LIMIT; cleared on
//    an instruction completion or iREN=0.
//  - tmo_cnt: cleared on IDLE entry, +1 each grant cycle without ACCESS; ramstate==ERROR or
//    tmo_cnt==TIMEOUT-1 -> ERR. ERR: no strobes, arb_err=1, waits follow requests; only nRST exits.
//  - Address/data are not latched; requesters hold them stable while their wait is high.
// STRUCTURE
//  - arb_state_t (IDLE, IGRANT, DGRANT, ERR) goes in cpu_types_pkg with word_t and ramstate_t.
//  - Single module, no sub-modules: a two-process FSM plus two counters.
// TESTING
//  1. iREN=1, iaddr=0x40, ACCESS 2 cycles after grant, ramload=0x8C220004 -> ramREN=1,
//     ramaddr=0x40, iwait=0 for 1 cycle with iload=0x8C220004, back to IDLE.
//  2. iREN and dWEN together, daddr=0x100, dstore=0xDEADBEEF -> DGRANT first, ramWEN=1,
//     ramstore=0xDEADBEEF, iwait held high; IGRANT follows.
//  3. iREN held, 5 back-to-back data reads with STARVE_LIMIT=4 -> 4 data completions, then
//     an instruction grant before the 5th data access.
//  4. Grant, ramstate held BUSY 16 cycles -> ERR on cycle 16, arb_err=1, strobes 0; nRST low
//     -> IDLE, arb_err=0.
//  5. DGRANT, drop dREN before ACCESS -> IDLE next cycle, dwait=0, starve_cnt unchanged.
//  6. nRST asserted mid-DGRANT -> ramREN/ramWEN=0 immediately (async), state IDLE.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU types: machine word, RAM handshake state, arbiter state
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    // Handshake status reported by the RAM for the access currently strobed.
    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    // Arbiter ownership of the RAM port.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IGRANT = 2'd1,
        DGRANT = 2'd2,
        ERR    = 2'd3
    } arb_state_t;

endpackage

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - single-port RAM arbiter between instruction fetch and data access
//
// Ports:
//   CLK, nRST                  clock (rising edge), asynchronous active-low reset
//   iREN, iaddr                instruction read request and address
//   iwait, iload               instruction stall (0 = iload valid) and read data
//   dREN, dWEN, daddr, dstore  data read/write request, address, write value
//   dwait, dload               data stall (0 = access completes) and read data
//   ramREN, ramWEN             registered RAM read/write strobes
//   ramaddr, ramstore          registered RAM address and write data
//   ramload, ramstate          RAM read data and handshake state
//   arb_err                    sticky error flag, cleared only by nRST
module ram_arbiter
    import cpu_types_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 16
) (
    input  logic      CLK,
    input  logic      nRST,
    input  logic      iREN,
    input  word_t     iaddr,
    output logic      iwait,
    output word_t     iload,
    input  logic      dREN,
    input  logic      dWEN,
    input  word_t     daddr,
    input  word_t     dstore,
    output logic      dwait,
    output word_t     dload,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    input  word_t     ramload,
    input  ramstate_t ramstate,
    output logic      arb_err
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

    arb_state_t    state, state_n;
    logic [SW-1:0] starve_cnt, starve_n;
    logic [TW-1:0] tmo_cnt, tmo_n;
    logic          ren_n, wen_n, err_n;
    word_t         addr_n, store_n;

    logic dreq, icomplete, dcomplete, grant_req;

    assign dreq      = dREN | dWEN;
    // A grant only completes while its owner still requests; a dropped
    // request in the ACCESS cycle is treated as a flush, not a completion.
    assign icomplete = (state == IGRANT) && iREN && (ramstate == ACCESS);
    assign dcomplete = (state == DGRANT) && dreq && (ramstate == ACCESS);
    assign grant_req = (state == IGRANT) ? iREN : dreq;

    assign iwait = iREN & ~icomplete;
    assign dwait = dreq & ~dcomplete;
    assign iload = ramload;
    assign dload = ramload;

    always_comb begin
        state_n = state;
        tmo_n   = tmo_cnt;
        case (state)
            IDLE: begin
                tmo_n = '0;
                if (dreq && !(iREN && (starve_cnt == STARVE_MAX)))
                    state_n = DGRANT;
                else if (iREN)
                    state_n = IGRANT;
            end
            IGRANT, DGRANT: begin
                if (!grant_req)
                    state_n = IDLE;
                else if (ramstate == ACCESS)
                    state_n = IDLE;
                else if ((ramstate == ERROR) || (tmo_cnt == TMO_LAST))
                    state_n = ERR;
                else
                    tmo_n = tmo_cnt + 1'b1;
            end
            ERR:     state_n = ERR;
            default: state_n = IDLE;
        endcase
    end

    // Instruction side is starving only while it keeps asking.
    always_comb begin
        starve_n = starve_cnt;
        if (!iREN || icomplete)
            starve_n = '0;
        else if (dcomplete && (starve_cnt != STARVE_MAX))
            starve_n = starve_cnt + 1'b1;
    end

    // Strobes are registered from the next state so they line up with the
    // grant state itself; address/data pass through from the holder each cycle.
    always_comb begin
        ren_n   = 1'b0;
        wen_n   = 1'b0;
        addr_n  = ramaddr;
        store_n = ramstore;
        case (state_n)
            IGRANT: begin
                ren_n  = 1'b1;
                addr_n = iaddr;
            end
            DGRANT: begin
                wen_n   = dWEN;
                ren_n   = dREN & ~dWEN;
                addr_n  = daddr;
                store_n = dstore;
            end
            default: ;
        endcase
        err_n = (state_n == ERR);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= IDLE;
            starve_cnt <= '0;
            tmo_cnt    <= '0;
            ramREN     <= 1'b0;
            ramWEN     <= 1'b0;
            ramaddr    <= '0;
            ramstore   <= '0;
            arb_err    <= 1'b0;
        end else begin
            state      <= state_n;
            starve_cnt <= starve_n;
            tmo_cnt    <= tmo_n;
            ramREN     <= ren_n;
            ramWEN     <= wen_n;
            ramaddr    <= addr_n;
            ramstore   <= store_n;
            arb_err    <= err_n;
        end
    end

endmodule
